logic_unit_arbiter: RTL

Shares one W-bit bitwise logic unit between four requesters using round-robin arbitration. Each requester presents an opcode and two operand vectors; the arbiter grants one request per cycle, evaluates the selected gate function, and registers the result with the winning requester's ID behind a valid/ready output handshake. The block sits between the requesting agents and the downstream result consumer, and replaces per-agent copies of the gate logic.

---
 rtl/logic_unit_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise logic unit among four
// requesters, with a registered valid/ready result slot and op counter.
module logic_unit_arbiter #(
  parameter int W    = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [11:0]     op,
  input  logic [4*W-1:0]  a,
  input  logic [4*W-1:0]  b,
  output logic [3:0]      gnt,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_data,
  output logic [1:0]      res_id,
  output logic [CNTW-1:0] ops_done
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic            valid_q, valid_d;
  logic [W-1:0]    data_q, data_d;
  logic [1:0]      id_q, id_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            free;
  logic            found;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            grant_en;
  logic [2:0]      sel_op;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [W-1:0]    alu_y;
  logic            accept;

  assign free   = ~valid_q | res_ready;
  assign accept = valid_q & res_ready;

  // Search starts at ptr and wraps, so the last winner goes to the back.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant_en = free & found & ~rst;
  assign gnt      = grant_en ? (4'b0001 << win) : 4'b0000;

  assign sel_op = op[3*win +: 3];
  assign sel_a  = a[W*win +: W];
  assign sel_b  = b[W*win +: W];

  always_comb begin
    alu_y = '0;
    unique case (sel_op)
      OP_AND:  alu_y = sel_a & sel_b;
      OP_OR:   alu_y = sel_a | sel_b;
      OP_XOR:  alu_y = sel_a ^ sel_b;
      OP_XNOR: alu_y = sel_a ~^ sel_b;
      OP_NOR:  alu_y = ~(sel_a | sel_b);
      OP_NAND: alu_y = ~(sel_a & sel_b);
      OP_NOT:  alu_y = ~sel_a;
      OP_PASS: alu_y = sel_a;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (grant_en) begin
      valid_d = 1'b1;
      data_d  = alu_y;
      id_d    = win;
      ptr_d   = win + 2'd1;
    end else if (res_ready) begin
      valid_d = 1'b0;
    end
  end

  // Saturating: stops at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !(&cnt_q)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign ops_done  = cnt_q;

endmodule
